shift_register_seq_ctrl: RTL and testbench

//  Sequencer for the 8-bit load/shift register. Accepts words on a valid/ready

---
 rtl/shift_register_seq_ctrl_pkg.sv | 18 +
 rtl/shift_register_seq_ctrl_cycle_counter.sv | 30 +++
 rtl/shift_register_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_shift_register_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_seq_ctrl_pkg.sv
// Shared state encoding, widths and helpers for the shift register sequencer.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} seq_state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);
   localparam int unsigned GAP_W         = 4;
   localparam int unsigned WORD_CNT_W    = 16;

   // One counter serves both the shift count and the gap count.
   function automatic int unsigned ctr_width(input int unsigned width);
      int unsigned w;
      w = $clog2(width);
      return (w > GAP_W) ? w : GAP_W;
   endfunction

endpackage

// File: rtl/shift_register_seq_ctrl_cycle_counter.sv
// Loadable down-counter; last_c flags the final cycle of a loaded count.
module sr_cycle_counter
   import shift_ctrl_pkg::*;
#(
   parameter int unsigned W = CNT_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last_c
);

   logic [W-1:0] count;

   // Saturates at zero so a stale count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign last_c = (count == W'(1));

endmodule

// File: rtl/shift_register_seq_ctrl.sv
// Sequencer that loads each accepted word into the shift register once and
// then shifts it NUM_SHIFTS times, with an optional idle gap between words.
module shift_register_seq_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned NUM_SHIFTS = 7,
   parameter int unsigned GAP_CYCLES = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,
   input  logic                  abort,
   output logic                  load_en,
   output logic                  shift_en,
   output logic [WIDTH-1:0]      sr_data,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_CNT_W-1:0] word_cnt
);

   localparam int unsigned CTR_W = ctr_width(WIDTH);

   if ((NUM_SHIFTS == 0) || (NUM_SHIFTS >= WIDTH)) begin : g_bad_num_shifts
      $error("shift_register_seq_ctrl: NUM_SHIFTS must be in 1..WIDTH-1");
   end
   if (GAP_CYCLES > 15) begin : g_bad_gap_cycles
      $error("shift_register_seq_ctrl: GAP_CYCLES must be in 0..15");
   end

   seq_state_t       state;
   logic             ctr_load_c;
   logic             ctr_dec_c;
   logic [CTR_W-1:0] ctr_val_c;
   logic             ctr_last_c;

   // Counter control: arm the shift count on LOAD, the gap count on the last shift.
   always_comb begin
      ctr_load_c = 1'b0;
      ctr_dec_c  = 1'b0;
      ctr_val_c  = '0;
      if (!abort) begin
         case (state)
            S_LOAD: begin
               ctr_load_c = 1'b1;
               ctr_val_c  = CTR_W'(NUM_SHIFTS);
            end
            S_SHIFT: begin
               if (ctr_last_c) begin
                  ctr_load_c = 1'b1;
                  ctr_val_c  = CTR_W'(GAP_CYCLES);
               end else begin
                  ctr_dec_c = 1'b1;
               end
            end
            S_GAP:   ctr_dec_c = 1'b1;
            default: ;
         endcase
      end
   end

   sr_cycle_counter #(.W(CTR_W)) u_cycle_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ctr_load_c),
      .load_val (ctr_val_c),
      .dec      (ctr_dec_c),
      .last_c   (ctr_last_c)
   );

   // Sequencer FSM; pulses default low and abort overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         in_ready <= 1'b1;
         load_en  <= 1'b0;
         shift_en <= 1'b0;
         sr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         word_cnt <= '0;
      end else begin
         load_en  <= 1'b0;
         shift_en <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (in_valid && in_ready) begin
                     state    <= S_LOAD;
                     load_en  <= 1'b1;
                     sr_data  <= in_data;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     in_ready <= 1'b1;
                  end
               end
               S_LOAD: begin
                  state    <= S_SHIFT;
                  shift_en <= 1'b1;
               end
               S_SHIFT: begin
                  if (ctr_last_c) begin
                     done     <= 1'b1;
                     word_cnt <= word_cnt + WORD_CNT_W'(1);
                     if (GAP_CYCLES == 0) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                     end else begin
                        state <= S_GAP;
                     end
                  end else begin
                     shift_en <= 1'b1;
                  end
               end
               S_GAP: begin
                  if (ctr_last_c) begin
                     state    <= S_IDLE;
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_register_seq_ctrl.sv
// Scoreboard bench for shift_register_seq_ctrl in two configurations:
// (NUM_SHIFTS=7, GAP_CYCLES=1) and (NUM_SHIFTS=3, GAP_CYCLES=0).
module tb_shift_register_seq_ctrl;

   typedef struct {
      logic [7:0]  word;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int c, input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL c%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", c, name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int unsigned NS     = (g == 0) ? 7 : 3;
      localparam int unsigned GAP    = (g == 0) ? 1 : 0;
      localparam int unsigned PERIOD = 2 + NS + GAP;

      logic        rst_n = 1'b1;
      logic        in_valid = 1'b0;
      logic        abort = 1'b0;
      logic [7:0]  in_data = '0;
      logic        in_ready, load_en, shift_en, busy, done;
      logic [7:0]  sr_data;
      logic [15:0] word_cnt;
      logic [7:0]  sr_reg = '0;
      bit          fin = 1'b0;
      exp_t        q[$];

      shift_register_seq_ctrl #(.WIDTH(8), .NUM_SHIFTS(NS), .GAP_CYCLES(GAP)) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_data  (in_data),
         .in_ready (in_ready),
         .abort    (abort),
         .load_en  (load_en),
         .shift_en (shift_en),
         .sr_data  (sr_data),
         .busy     (busy),
         .done     (done),
         .word_cnt (word_cnt)
      );

      // Downstream register: load wins, shifts toward the LSB.
      always @(posedge clk) begin
         if (load_en) sr_reg <= sr_data;
         else if (shift_en) sr_reg <= sr_reg >> 1;
      end

      always @(negedge clk) if (rst_n) assert (!(load_en && shift_en));

      task automatic idle(input int unsigned n);
         repeat (n) @(posedge clk);
         #1;
      endtask

      task automatic wait_cyc(input int unsigned n);
         while (cyc < n) begin
            @(posedge clk);
            #1;
         end
      endtask

      // Offer a word; on handshake push its expected timeline into the scoreboard.
      task automatic send(input logic [7:0] d, input bit hold, output int unsigned acc);
         bit got;
         got = 1'b0;
         acc = 0;
         in_valid = 1'b1;
         in_data  = d;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready && !abort) begin
               got = 1'b1;
               acc = cyc;
               q.push_back('{d, cyc});
            end
            @(posedge clk);
            #1;
         end
         if (!got) chk(g, "handshake_timeout", 32'(0), 32'(1));
         if (!hold) in_valid = 1'b0;
      endtask

      // Monitor: expected outputs derived from accept time and the word timeline.
      int unsigned t0 = 0;
      bit          act = 1'b0;
      bit          abort_prev = 1'b0;
      logic [7:0]  cur_word = '0;
      logic [7:0]  exp_sr = '0;
      logic [15:0] exp_cnt = '0;

      always @(negedge clk) begin : mon
         int unsigned k;
         bit e_load, e_shift, e_done, e_busy;
         if (!rst_n) begin
            chk(g, "rst_in_ready", 32'(in_ready), 32'(1));
            chk(g, "rst_load_en",  32'(load_en),  32'(0));
            chk(g, "rst_shift_en", 32'(shift_en), 32'(0));
            chk(g, "rst_sr_data",  32'(sr_data),  32'(0));
            chk(g, "rst_busy",     32'(busy),     32'(0));
            chk(g, "rst_done",     32'(done),     32'(0));
            chk(g, "rst_word_cnt", 32'(word_cnt), 32'(0));
            act = 1'b0; abort_prev = 1'b0; exp_cnt = '0; exp_sr = '0;
            q.delete();
         end else begin
            if (q.size() != 0 && cyc == q[0].acc + 1) begin
               cur_word = q[0].word;
               t0 = q[0].acc;
               void'(q.pop_front());
               act = 1'b1;
            end
            k = cyc - t0;
            e_load  = act && (k == 1);
            e_shift = act && (k >= 2) && (k <= NS + 1);
            e_done  = act && (k == NS + 2);
            e_busy  = act && (k <= NS + 1 + GAP);
            if (e_load) exp_sr = cur_word;
            if (e_done) exp_cnt = exp_cnt + 16'd1;
            chk(g, "load_en",  32'(load_en),  32'(e_load));
            chk(g, "shift_en", 32'(shift_en), 32'(e_shift));
            chk(g, "done",     32'(done),     32'(e_done));
            chk(g, "busy",     32'(busy),     32'(e_busy));
            chk(g, "in_ready", 32'(in_ready), 32'(!e_busy && !abort_prev));
            chk(g, "sr_data",  32'(sr_data),  32'(exp_sr));
            chk(g, "word_cnt", 32'(word_cnt), 32'(exp_cnt));
            chk(g, "load_and_shift", 32'(load_en & shift_en), 32'(0));
            if (e_done) chk(g, "sr_reg_final", 32'(sr_reg), 32'(cur_word >> NS));
            abort_prev = abort;
            if (abort) act = 1'b0;
         end
      end

      initial begin : stim
         int unsigned a1, a2, r;
         #1 rst_n = 1'b0;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;

         send(8'h80, 1'b0, a1);
         idle(PERIOD + 2);

         send(8'hA1, 1'b1, a1);
         send(8'h00, 1'b0, a2);
         chk(g, "b2b_period", a2 - a1, PERIOD);
         idle(PERIOD + 2);

         // Abort on the third shift cycle.
         send(8'hFF, 1'b0, a1);
         wait_cyc(a1 + 4);
         abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
         idle(PERIOD + 2);

         // Abort together with a valid word in IDLE: the word stays offered.
         in_valid = 1'b1; in_data = 8'h5A; abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
         send(8'h5A, 1'b0, a1);
         idle(PERIOD + 2);

         // Asynchronous reset in the middle of SHIFT.
         send(8'h3C, 1'b0, a1);
         wait_cyc(a1 + 3);
         #2 rst_n = 1'b0;
         #1;
         chk(g, "async_in_ready", 32'(in_ready), 32'(1));
         chk(g, "async_load_en",  32'(load_en),  32'(0));
         chk(g, "async_shift_en", 32'(shift_en), 32'(0));
         chk(g, "async_sr_data",  32'(sr_data),  32'(0));
         chk(g, "async_busy",     32'(busy),     32'(0));
         chk(g, "async_word_cnt", 32'(word_cnt), 32'(0));
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         send(8'hC3, 1'b0, a1);
         idle(PERIOD + 2);

         for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'b0, a1);
            if ($urandom_range(0, 4) == 0) begin
               r = $urandom_range(0, PERIOD);
               wait_cyc(a1 + 1 + r);
               abort = 1'b1;
               @(posedge clk); #1 abort = 1'b0;
            end
            idle($urandom_range(0, 3));
         end
         idle(PERIOD + 2);
         fin = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 60000; i++) begin
         if (cfg[0].fin && cfg[1].fin) break;
         @(posedge clk);
      end
      if (!(cfg[0].fin && cfg[1].fin)) begin
         vectors++;
         miscompares++;
         $display("FAIL run_timeout: stimulus did not complete, expected completion");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
